// File: rtl/memoria_dados_pkg.sv
// Shared definitions for the nRisc data-side responder: MMIO offsets,
// STATUS bit layout, default window base and the address decoder.
package memoria_dados_pkg;

  localparam logic [7:0] BASE_MMIO_PADRAO = 8'hF0;

  localparam logic [7:0] OFS_SAIDA     = 8'd0;
  localparam logic [7:0] OFS_ENTRADA   = 8'd1;
  localparam logic [7:0] OFS_CONTADOR  = 8'd2;
  localparam logic [7:0] OFS_FIFO_DADO = 8'd3;
  localparam logic [7:0] OFS_STATUS    = 8'd4;

  localparam int unsigned ST_VAZIO     = 0;
  localparam int unsigned ST_CHEIO     = 1;
  localparam int unsigned ST_OCUP_LSB  = 2;
  localparam int unsigned ST_OCUP_MSB  = 4;
  localparam int unsigned ST_OVERFLOW  = 7;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_SAIDA,
    SEL_ENTRADA,
    SEL_CONTADOR,
    SEL_FIFO_DADO,
    SEL_STATUS,
    SEL_NADA
  } sel_e;

  // Maps a byte address onto the RAM or one of the MMIO registers.
  function automatic sel_e decodifica(input logic [7:0] endereco,
                                      input logic [7:0] base);
    logic [7:0] ofs;
    sel_e       sel;
    ofs = endereco - base;
    if (endereco < base) begin
      sel = SEL_RAM;
    end else begin
      case (ofs)
        OFS_SAIDA:     sel = SEL_SAIDA;
        OFS_ENTRADA:   sel = SEL_ENTRADA;
        OFS_CONTADOR:  sel = SEL_CONTADOR;
        OFS_FIFO_DADO: sel = SEL_FIFO_DADO;
        OFS_STATUS:    sel = SEL_STATUS;
        default:       sel = SEL_NADA;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/memoria_dados_mmio_if.sv
// Core data bus plus the TX byte stream, bundled for the data responder.
interface memoria_dados_mmio_if;
  logic [7:0] EnderecoDados;
  logic [7:0] DadoEscrito;
  logic       MemWrite;
  logic       MemRead;
  logic [7:0] DadoLido;
  logic [7:0] TxDado;
  logic       TxValid;
  logic       TxReady;

  modport master (
    output EnderecoDados, DadoEscrito, MemWrite, MemRead, TxReady,
    input  DadoLido, TxDado, TxValid
  );

  modport slave (
    input  EnderecoDados, DadoEscrito, MemWrite, MemRead, TxReady,
    output DadoLido, TxDado, TxValid
  );
endinterface

// File: rtl/memoria_dados_mmio_fifo_tx.sv
// Parameterized synchronous FIFO feeding the TX stream. The head byte is
// forced to zero while empty so the stream output is clean after reset.
module fifo_tx #(
  parameter  int unsigned PROFUNDIDADE = 4,
  parameter  int unsigned LARGURA      = 8,
  localparam int unsigned LARG_PTR     = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1,
  localparam int unsigned LARG_OCUP    = $clog2(PROFUNDIDADE + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 push,
  input  logic [LARGURA-1:0]   dado_in,
  input  logic                 pop,
  output logic [LARGURA-1:0]   dado_out,
  output logic                 vazio,
  output logic                 cheio,
  output logic [LARG_OCUP-1:0] ocupacao
);

  localparam logic [LARG_PTR-1:0]  PTR_ULTIMO = LARG_PTR'(PROFUNDIDADE - 1);
  localparam logic [LARG_OCUP-1:0] OCUP_MAX   = LARG_OCUP'(PROFUNDIDADE);

  logic [LARGURA-1:0]   mem_q [PROFUNDIDADE];
  logic [LARG_PTR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LARG_PTR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LARG_OCUP-1:0] ocup_q, ocup_d;
  logic                 push_ok, pop_ok;

  function automatic logic [LARG_PTR-1:0] avanca(input logic [LARG_PTR-1:0] p);
    return (p == PTR_ULTIMO) ? '0 : p + LARG_PTR'(1);
  endfunction

  // Accept/pop decisions, pointer and occupancy next-state, head byte.
  always_comb begin
    vazio    = (ocup_q == '0);
    cheio    = (ocup_q == OCUP_MAX);
    pop_ok   = pop && !vazio;
    push_ok  = push && (!cheio || pop_ok);
    rd_ptr_d = pop_ok  ? avanca(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_ok ? avanca(wr_ptr_q) : wr_ptr_q;
    ocup_d   = ocup_q;
    case ({push_ok, pop_ok})
      2'b10:   ocup_d = ocup_q + LARG_OCUP'(1);
      2'b01:   ocup_d = ocup_q - LARG_OCUP'(1);
      default: ocup_d = ocup_q;
    endcase
    dado_out = vazio ? '0 : mem_q[rd_ptr_q];
  end

  assign ocupacao = ocup_q;

  // Pointer and occupancy registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ocup_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ocup_q   <= ocup_d;
    end
  end

  // Storage; contents need no reset because an empty FIFO masks the head.
  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= dado_in;
    end
  end

endmodule

// File: rtl/memoria_dados_mmio.sv
// Data-side responder for the 8-bit nRisc core: RAM below BASE_MMIO and an
// MMIO window with output port, synchronized input, cycle counter and TX FIFO.
module memoria_dados_mmio
  import memoria_dados_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE_FIFO = 4,
  parameter logic [7:0]  BASE_MMIO         = BASE_MMIO_PADRAO
) (
  input  logic                 Clock,
  input  logic                 Reset,
  memoria_dados_mmio_if.slave  barramento,
  input  logic [7:0]           PortaEntrada,
  output logic [7:0]           PortaSaida
);

  localparam int unsigned TAM_RAM   = int'(BASE_MMIO);
  localparam int unsigned LARG_OCUP = $clog2(PROFUNDIDADE_FIFO + 1);

  sel_e                 sel;
  logic                 escrita, leitura;
  logic [7:0]           ram_q [TAM_RAM];
  logic                 ram_we;
  logic [7:0]           saida_q, saida_d;
  logic [7:0]           sinc1_q, sinc1_d;
  logic [7:0]           sinc2_q, sinc2_d;
  logic [7:0]           contador_q, contador_d;
  logic                 overflow_q, overflow_d;
  logic                 tentativa_push, fifo_pop;
  logic                 fifo_vazio, fifo_cheio;
  logic [LARG_OCUP-1:0] fifo_ocupacao;
  logic [7:0]           fifo_dado_out;
  logic [7:0]           status;

  assign sel     = decodifica(barramento.EnderecoDados, BASE_MMIO);
  assign escrita = barramento.MemWrite;
  assign leitura = barramento.MemRead;

  fifo_tx #(
    .PROFUNDIDADE (PROFUNDIDADE_FIFO),
    .LARGURA      (8)
  ) u_fifo_tx (
    .Clock    (Clock),
    .Reset    (Reset),
    .push     (tentativa_push),
    .dado_in  (barramento.DadoEscrito),
    .pop      (fifo_pop),
    .dado_out (fifo_dado_out),
    .vazio    (fifo_vazio),
    .cheio    (fifo_cheio),
    .ocupacao (fifo_ocupacao)
  );

  assign barramento.TxDado  = fifo_dado_out;
  assign barramento.TxValid = !fifo_vazio;

  // Register next-state: port, synchronizer, counter, overflow, RAM strobe.
  always_comb begin
    ram_we         = escrita && (sel == SEL_RAM) && Reset;
    saida_d        = (escrita && (sel == SEL_SAIDA)) ? barramento.DadoEscrito : saida_q;
    sinc1_d        = PortaEntrada;
    sinc2_d        = sinc1_q;
    contador_d     = (escrita && (sel == SEL_CONTADOR)) ? '0 : contador_q + 8'd1;
    tentativa_push = escrita && (sel == SEL_FIFO_DADO);
    fifo_pop       = !fifo_vazio && barramento.TxReady;
    // Setting has priority so an overflow in the clearing cycle survives.
    overflow_d     = overflow_q;
    if (leitura && (sel == SEL_STATUS)) begin
      overflow_d = 1'b0;
    end
    if (tentativa_push && fifo_cheio && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  // Read mux; combinational so the single-cycle core sees data the same cycle.
  always_comb begin
    status                          = '0;
    status[ST_VAZIO]                = fifo_vazio;
    status[ST_CHEIO]                = fifo_cheio;
    status[ST_OCUP_MSB:ST_OCUP_LSB] = 3'(fifo_ocupacao);
    status[ST_OVERFLOW]             = overflow_q;
    barramento.DadoLido             = '0;
    if (leitura) begin
      case (sel)
        SEL_RAM:      barramento.DadoLido = ram_q[barramento.EnderecoDados];
        SEL_SAIDA:    barramento.DadoLido = saida_q;
        SEL_ENTRADA:  barramento.DadoLido = sinc2_q;
        SEL_CONTADOR: barramento.DadoLido = contador_q;
        SEL_STATUS:   barramento.DadoLido = status;
        default:      barramento.DadoLido = '0;
      endcase
    end
  end

  // MMIO state registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      saida_q    <= '0;
      sinc1_q    <= '0;
      sinc2_q    <= '0;
      contador_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      saida_q    <= saida_d;
      sinc1_q    <= sinc1_d;
      sinc2_q    <= sinc2_d;
      contador_q <= contador_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge Clock) begin
    if (ram_we) begin
      ram_q[barramento.EnderecoDados] <= barramento.DadoEscrito;
    end
  end

  assign PortaSaida = saida_q;

endmodule

// File: doc/memoria_dados_mmio.md
# memoria_dados_mmio

Data-side responder for the 8-bit nRisc core. It answers the core's data interface: address, write data, MemWrite and MemRead in, read data out. It provides 240 bytes of RAM plus a small memory-mapped I/O window: an output port, a synchronized input port, a cycle counter, and a 4-entry transmit FIFO drained through a valid/ready stream. It sits beside the core at top level, in place of a plain data memory.

## Interface
- PROFUNDIDADE_FIFO, 4, TX FIFO depth; legal values 2 or 4.
- BASE_MMIO, 8'hF0, first address of the MMIO window; must be 8'hF0 or above.
- Clock  in  1  single clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset.
- EnderecoDados  in  8  byte address from the core.
- DadoEscrito  in  8  write data from the core.
- MemWrite  in  1  write strobe for the current cycle.
- MemRead  in  1  read strobe for the current cycle.
- DadoLido  out  8  read data; combinational, same cycle.
- PortaEntrada  in  8  asynchronous external input.
- PortaSaida  out  8  output port register.
- TxDado  out  8  FIFO head byte.
- TxValid  out  1  FIFO non-empty.
- TxReady  in  1  consumer accepts TxDado.

## Operation
- Address map:
  - 0x00..BASE_MMIO-1: RAM, read/write. RAM contents are not affected by reset.
  - BASE+0 SAIDA: read/write; drives PortaSaida.
  - BASE+1 ENTRADA: read-only; PortaEntrada after a 2-flop synchronizer.
  - BASE+2 CONTADOR: free-running, increments every cycle, wraps 0xFF->0x00. A write of any value clears it to 0x00; the write beats the increment.
  - BASE+3 FIFO_DADO: a write pushes DadoEscrito; a read returns 0x00.
  - BASE+4 STATUS: read-only.
    - bit0 = empty
    - bit1 = full
    - bits4:2 = occupancy (0..PROFUNDIDADE_FIFO)
    - bit7 = sticky overflow
    - bits6:5 = 0
  - BASE+5..0xFF: reads return 0x00; writes are ignored.
- DadoLido = 0x00 whenever MemRead=0.
- MemRead and MemWrite both high: the write commits on the edge; DadoLido shows the pre-edge value.
- FIFO push is accepted when occupancy < depth, or when a pop happens in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets overflow.
- A pop occurs when TxValid && TxReady. Simultaneous push and pop leaves occupancy unchanged and keeps FIFO order.
- Overflow clears on the edge of a cycle with MemRead=1 and address BASE+4.
  - If a new overflow occurs in that same cycle, overflow stays set.
- Read/write pointers wrap modulo depth.

## Timing
- Reset (Reset=0 at a rising edge) sets:
  - PortaSaida=0x00
  - CONTADOR=0x00
  - synchronizer flops=0x00
  - FIFO empty, TxValid=0, TxDado=0x00
  - overflow=0
- Reset wins over every concurrent write, push or pop. A byte in flight on the stream is discarded.
- Read latency is 0 cycles (combinational from address and registers), as required by the single-cycle core.
- Write latency: the new value is visible to reads in the cycle after the write edge.
- ENTRADA reflects a PortaEntrada change 2 edges after it is sampled.
- TxValid rises the cycle after the pushing edge. TxDado is stable while TxValid=1 and TxReady=0.
- The stream rule: TxValid never depends on TxReady.

## Structure
- Shared package memoria_dados_pkg holds:
  - offsets OFS_SAIDA, OFS_ENTRADA, OFS_CONTADOR, OFS_FIFO_DADO, OFS_STATUS
  - STATUS bit positions
  - default BASE_MMIO
- One sub-module, fifo_tx: a parameterized synchronous FIFO.
  - Ports: push/dado_in/pop/dado_out/vazio/cheio/ocupacao, same Clock/Reset.
- The top handles address decode, RAM array, SAIDA, synchronizer, counter, overflow flag and the read mux.

## Test plan
- RAM: write 0x5A to 0x10, then read 0x10 with MemRead -> DadoLido=0x5A. Read 0x10 with MemRead=0 -> 0x00. Reset, then read 0x10 -> still 0x5A.
- MMIO port and counter:
  - Write 0xC3 to 0xF0 -> PortaSaida=0xC3 next cycle.
  - Drive PortaEntrada=0x81 -> read 0xF1 gives 0x81 after 2 edges.
  - Write 0xF2 -> CONTADOR reads 0x00, then 0x01, 0x02 on following cycles; it wraps after 0xFF.
- FIFO fill, TxReady=0:
  - Push 0x11,0x22,0x33,0x44 -> STATUS=0x12 (full, count 4).
  - 5th push 0x55 is dropped -> STATUS=0x92.
  - Read STATUS -> 0x92, then 0x12 on the next read.
- FIFO drain with TxReady=1: TxDado sequence is 0x11,0x22,0x33,0x44 on consecutive cycles, then TxValid=0 and STATUS=0x01.
- Full FIFO with simultaneous push 0x66 and pop (TxReady=1) -> accepted, count stays 4, no overflow, 0x66 emerges last.
- Reset mid-operation (FIFO holding 3, counter at 0x7F, PortaSaida=0xAA), Reset=0 for one edge -> TxValid=0, STATUS=0x01, CONTADOR=0x00, PortaSaida=0x00. A simultaneous write to 0xF0 is ignored.
